// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator: round-robin head arbitration, lock until tail, crossbar selects.
// Latency: grant 1 cycle after request; backpressure: o_grant gated combinationally by i_credit_avail. Option: SW_ALLOC_WATCHDOG_EN.
module switch_allocator #(
   parameter  int NUM_PORTS = 5,
   parameter  int WD_CYCLES = 255,
   localparam int PW        = $clog2(NUM_PORTS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_PORTS-1:0]    i_req_valid,
   input  logic [NUM_PORTS*PW-1:0] i_req_port,
   input  logic [NUM_PORTS-1:0]    i_flit_fire,
   input  logic [NUM_PORTS-1:0]    i_flit_tail,
   input  logic [NUM_PORTS-1:0]    i_credit_avail,
   output logic [NUM_PORTS-1:0]    o_grant,
   output logic [NUM_PORTS*PW-1:0] o_xbar_sel,
   output logic [NUM_PORTS-1:0]    o_out_active,
   output logic [NUM_PORTS-1:0]    o_wd_timeout
);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   if (NUM_PORTS < 2 || WD_CYCLES < 1) begin : g_param_check
      $error("switch_allocator: NUM_PORTS must be >= 2 and WD_CYCLES >= 1");
   end

   state_t              state_q [NUM_PORTS];
   state_t              state_d [NUM_PORTS];
   logic [PW-1:0]       owner_q [NUM_PORTS];
   logic [PW-1:0]       owner_d [NUM_PORTS];
   logic [PW-1:0]       rr_q    [NUM_PORTS];
   logic [PW-1:0]       rr_d    [NUM_PORTS];
   logic [NUM_PORTS-1:0] elig   [NUM_PORTS];
   logic [NUM_PORTS-1:0] in_locked;
   logic [NUM_PORTS-1:0] grant;

   // Returns {found, index} of first set bit at or after ptr, wrapping.
   function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                           input logic [PW-1:0]        ptr);
      logic [PW:0] res;
      int          idx;
      res = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (req[idx]) res = {1'b1, PW'(idx)};
      end
      return res;
   endfunction

   function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
      return (int'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
   endfunction

   always_comb begin : lock_decode
      in_locked = '0;
      grant     = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (state_q[o] == LOCKED && owner_q[o] == PW'(i)) begin
               in_locked[i] = 1'b1;
               if (i_credit_avail[o]) grant[i] = 1'b1;
            end
         end
      end
   end

   // Out-of-range request ports never match any output index.
   always_comb begin : eligibility
      for (int o = 0; o < NUM_PORTS; o++) begin
         elig[o] = '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            elig[o][i] = i_req_valid[i] && !in_locked[i] &&
                         (i_req_port[i*PW +: PW] == PW'(o));
         end
      end
   end

`ifdef SW_ALLOC_WATCHDOG_EN
   localparam int CW = $clog2(WD_CYCLES + 1);
   logic [CW-1:0]        wd_cnt_q [NUM_PORTS];
   logic [CW-1:0]        wd_cnt_d [NUM_PORTS];
   logic [NUM_PORTS-1:0] wd_to_q;
   logic [NUM_PORTS-1:0] wd_to_d;
`endif

   always_comb begin : next_state
      logic [PW:0] pick;
      logic [PW-1:0] own;
      pick = '0;
      own  = '0;
`ifdef SW_ALLOC_WATCHDOG_EN
      wd_to_d = '0;
`endif
      for (int o = 0; o < NUM_PORTS; o++) begin
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
         rr_d[o]    = rr_q[o];
         own        = owner_q[o];
`ifdef SW_ALLOC_WATCHDOG_EN
         wd_cnt_d[o] = wd_cnt_q[o];
`endif
         case (state_q[o])
            IDLE: begin
               pick = rr_pick(elig[o], rr_q[o]);
               if (pick[PW]) begin
                  state_d[o] = LOCKED;
                  owner_d[o] = pick[PW-1:0];
`ifdef SW_ALLOC_WATCHDOG_EN
                  wd_cnt_d[o] = '0;
`endif
               end
            end
            LOCKED: begin
               if (i_flit_fire[own] && i_flit_tail[own] && grant[own]) begin
                  state_d[o] = IDLE;
                  rr_d[o]    = next_port(own);
               end
`ifdef SW_ALLOC_WATCHDOG_EN
               // Force release of a stalled owner so the output cannot wedge.
               else if (wd_cnt_q[o] == CW'(WD_CYCLES)) begin
                  state_d[o] = IDLE;
                  rr_d[o]    = next_port(own);
                  wd_to_d[o] = 1'b1;
               end else if (i_flit_fire[own] && grant[own]) begin
                  wd_cnt_d[o] = '0;
               end else begin
                  wd_cnt_d[o] = wd_cnt_q[o] + 1'b1;
               end
`endif
            end
            default: state_d[o] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            state_q[o] <= IDLE;
            owner_q[o] <= '0;
            rr_q[o]    <= '0;
`ifdef SW_ALLOC_WATCHDOG_EN
            wd_cnt_q[o] <= '0;
`endif
         end
`ifdef SW_ALLOC_WATCHDOG_EN
         wd_to_q <= '0;
`endif
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
            rr_q[o]    <= rr_d[o];
`ifdef SW_ALLOC_WATCHDOG_EN
            wd_cnt_q[o] <= wd_cnt_d[o];
`endif
         end
`ifdef SW_ALLOC_WATCHDOG_EN
         wd_to_q <= wd_to_d;
`endif
      end
   end

   always_comb begin : outputs
      o_grant      = grant;
      o_xbar_sel   = '0;
      o_out_active = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         o_out_active[o] = (state_q[o] == LOCKED);
         if (state_q[o] == LOCKED) o_xbar_sel[o*PW +: PW] = owner_q[o];
      end
   end

`ifdef SW_ALLOC_WATCHDOG_EN
   assign o_wd_timeout = wd_to_q;
`else
   assign o_wd_timeout = '0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Directed vector bench for switch_allocator (default build): table of per-cycle stimulus and expected outputs.
module tb_switch_allocator;

   localparam int N  = 5;
   localparam int PW = 3;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]    i_req_valid;
   logic [N*PW-1:0] i_req_port;
   logic [N-1:0]    i_flit_fire;
   logic [N-1:0]    i_flit_tail;
   logic [N-1:0]    i_credit_avail;
   logic [N-1:0]    o_grant;
   logic [N*PW-1:0] o_xbar_sel;
   logic [N-1:0]    o_out_active;
   logic [N-1:0]    o_wd_timeout;

   switch_allocator #(.NUM_PORTS(N), .WD_CYCLES(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req_valid   (i_req_valid),
      .i_req_port    (i_req_port),
      .i_flit_fire   (i_flit_fire),
      .i_flit_tail   (i_flit_tail),
      .i_credit_avail(i_credit_avail),
      .o_grant       (o_grant),
      .o_xbar_sel    (o_xbar_sel),
      .o_out_active  (o_out_active),
      .o_wd_timeout  (o_wd_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string           name;
      logic [N-1:0]    req;
      logic [N*PW-1:0] port;
      logic [N-1:0]    fire;
      logic [N-1:0]    tail;
      logic [N-1:0]    credit;
      logic [N-1:0]    exp_grant;
      logic [N*PW-1:0] exp_sel;
      logic [N-1:0]    exp_active;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [N*PW-1:0] ports(int p4, int p3, int p2, int p1, int p0);
      return {3'(p4), 3'(p3), 3'(p2), 3'(p1), 3'(p0)};
   endfunction

   function automatic void add(string nm, logic [N-1:0] req, logic [N*PW-1:0] port,
                               logic [N-1:0] fire, logic [N-1:0] tail, logic [N-1:0] credit,
                               logic [N-1:0] eg, logic [N*PW-1:0] es, logic [N-1:0] ea);
      vec_t v;
      v.name = nm; v.req = req; v.port = port; v.fire = fire; v.tail = tail;
      v.credit = credit; v.exp_grant = eg; v.exp_sel = es; v.exp_active = ea;
      vecs.push_back(v);
   endfunction

   task automatic check(string nm, logic [N-1:0] eg, logic [N*PW-1:0] es, logic [N-1:0] ea);
      n_vec++;
      if (o_grant !== eg) begin
         n_err++;
         $display("FAIL %s o_grant got %b want %b", nm, o_grant, eg);
      end
      if (o_xbar_sel !== es) begin
         n_err++;
         $display("FAIL %s o_xbar_sel got %h want %h", nm, o_xbar_sel, es);
      end
      if (o_out_active !== ea) begin
         n_err++;
         $display("FAIL %s o_out_active got %b want %b", nm, o_out_active, ea);
      end
      if (o_wd_timeout !== 5'b0) begin
         n_err++;
         $display("FAIL %s o_wd_timeout got %b want 00000", nm, o_wd_timeout);
      end
   endtask

   task automatic drive(logic [N-1:0] req, logic [N*PW-1:0] port, logic [N-1:0] fire,
                        logic [N-1:0] tail, logic [N-1:0] credit);
      i_req_valid = req; i_req_port = port; i_flit_fire = fire;
      i_flit_tail = tail; i_credit_avail = credit;
   endtask

   initial begin
      logic [N*PW-1:0] p_none, p13, p_par, p_bad, p_cont, p20;
      p_none = '0;
      p13    = ports(0, 0, 0, 3, 0);
      p_par  = ports(0, 4, 0, 0, 2);
      p_bad  = ports(0, 0, 7, 0, 0);
      p_cont = ports(1, 0, 1, 0, 1);
      p20    = ports(0, 0, 0, 0, 0);

      // single request: input 1 -> output 3, three flits
      add("single_req",   5'b00010, p13,    5'b00000, 5'b00000, 5'h1F, 5'b00000, 15'h0000, 5'b00000);
      add("single_f1",    5'b00000, p_none, 5'b00010, 5'b00000, 5'h1F, 5'b00010, 15'h0200, 5'b01000);
      add("single_f2",    5'b00000, p_none, 5'b00010, 5'b00000, 5'h1F, 5'b00010, 15'h0200, 5'b01000);
      add("single_tail",  5'b00000, p_none, 5'b00010, 5'b00010, 5'h1F, 5'b00010, 15'h0200, 5'b01000);
      add("single_rel",   5'b00000, p_none, 5'b00000, 5'b00000, 5'h1F, 5'b00000, 15'h0000, 5'b00000);
      // parallel outputs: 0 -> 2, 3 -> 4
      add("par_req",      5'b01001, p_par,  5'b00000, 5'b00000, 5'h1F, 5'b00000, 15'h0000, 5'b00000);
      add("par_lock",     5'b00000, p_none, 5'b00000, 5'b00000, 5'h1F, 5'b01001, 15'h3000, 5'b10100);
      // credit stall on output 2 (owner 0), illegal tail fire without grant
      add("stall_1",      5'b00000, p_none, 5'b00000, 5'b00000, 5'h1B, 5'b01000, 15'h3000, 5'b10100);
      add("stall_2_ill",  5'b00000, p_none, 5'b00001, 5'b00001, 5'h1B, 5'b01000, 15'h3000, 5'b10100);
      add("stall_3",      5'b00000, p_none, 5'b00000, 5'b00000, 5'h1B, 5'b01000, 15'h3000, 5'b10100);
      add("stall_4",      5'b00000, p_none, 5'b00000, 5'b00000, 5'h1B, 5'b01000, 15'h3000, 5'b10100);
      add("stall_resume", 5'b00000, p_none, 5'b01000, 5'b01000, 5'h1F, 5'b01001, 15'h3000, 5'b10100);
      add("par_tail0",    5'b00000, p_none, 5'b00001, 5'b00001, 5'h1F, 5'b00001, 15'h0000, 5'b00100);
      // illegal request port 7
      add("bad_port_a",   5'b00100, p_bad,  5'b00000, 5'b00000, 5'h1F, 5'b00000, 15'h0000, 5'b00000);
      add("bad_port_b",   5'b00100, p_bad,  5'b00000, 5'b00000, 5'h1F, 5'b00000, 15'h0000, 5'b00000);
      // contention on output 1 from inputs 0, 2, 4 with 2-flit packets
      add("rr_req",       5'b10101, p_cont, 5'b00000, 5'b00000, 5'h1F, 5'b00000, 15'h0000, 5'b00000);
      add("rr_0_f1",      5'b10101, p_cont, 5'b00001, 5'b00000, 5'h1F, 5'b00001, 15'h0000, 5'b00010);
      add("rr_0_tail",    5'b10101, p_cont, 5'b00001, 5'b00001, 5'h1F, 5'b00001, 15'h0000, 5'b00010);
      add("rr_gap1",      5'b10101, p_cont, 5'b00000, 5'b00000, 5'h1F, 5'b00000, 15'h0000, 5'b00000);
      add("rr_2_f1",      5'b10101, p_cont, 5'b00100, 5'b00000, 5'h1F, 5'b00100, 15'h0010, 5'b00010);
      add("rr_2_tail",    5'b10101, p_cont, 5'b00100, 5'b00100, 5'h1F, 5'b00100, 15'h0010, 5'b00010);
      add("rr_gap2",      5'b10101, p_cont, 5'b00000, 5'b00000, 5'h1F, 5'b00000, 15'h0000, 5'b00000);
      add("rr_4_f1",      5'b10101, p_cont, 5'b10000, 5'b00000, 5'h1F, 5'b10000, 15'h0020, 5'b00010);
      add("rr_4_tail",    5'b10101, p_cont, 5'b10000, 5'b10000, 5'h1F, 5'b10000, 15'h0020, 5'b00010);
      add("rr_gap3",      5'b10101, p_cont, 5'b00000, 5'b00000, 5'h1F, 5'b00000, 15'h0000, 5'b00000);
      add("rr_0_again",   5'b10101, p_cont, 5'b00001, 5'b00000, 5'h1F, 5'b00001, 15'h0000, 5'b00010);

      rst_n = 1'b0;
      drive('0, '0, '0, '0, 5'h1F);
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 5'b00000, 15'h0000, 5'b00000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[k]) begin
         drive(vecs[k].req, vecs[k].port, vecs[k].fire, vecs[k].tail, vecs[k].credit);
         @(negedge clk);
         check(vecs[k].name, vecs[k].exp_grant, vecs[k].exp_sel, vecs[k].exp_active);
         @(posedge clk);
         #1;
      end

      // output 1 still locked to input 0 mid-packet: async reset clears it without a clock edge
      drive('0, '0, '0, '0, 5'h1F);
      #1;
      check("pre_reset_lock", 5'b00001, 15'h0000, 5'b00010);
      rst_n = 1'b0;
      #1;
      check("async_reset", 5'b00000, 15'h0000, 5'b00000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single-flit packet: input 2 -> output 0, head carries tail
      drive(5'b00100, p20, '0, '0, 5'h1F);
      @(negedge clk);
      check("sflit_req", 5'b00000, 15'h0000, 5'b00000);
      @(posedge clk);
      #1;
      drive('0, '0, 5'b00100, 5'b00100, 5'h1F);
      @(negedge clk);
      check("sflit_fire", 5'b00100, 15'h0002, 5'b00001);
      @(posedge clk);
      #1;
      drive('0, '0, '0, '0, 5'h1F);
      @(negedge clk);
      check("sflit_rel", 5'b00000, 15'h0000, 5'b00000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-output wormhole switch allocator for the 5-port mesh router. Each cycle it collects head-flit requests from the input pipelines, runs an independent round-robin arbitration for every idle output, locks the winning input to that output until the packet's tail flit has crossed, and drives the crossbar select lines. It sits between the route-compute stage and the crossbar/switch datapath. It replaces the ad-hoc per-port status tracking with one registered owner per output.

## Interface
- NUM_PORTS, 5: router ports (0=local, 1..4 = N/E/S/W); port index width PW = $clog2(NUM_PORTS)
- WD_CYCLES, 255: watchdog limit in cycles, used only with the watchdog macro
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  NUM_PORTS  input i has a head flit requesting an output
- i_req_port  in  NUM_PORTS*PW  requested output for input i, slice [i*PW +: PW]
- i_flit_fire  in  NUM_PORTS  input i transfers a flit through the crossbar this cycle
- i_flit_tail  in  NUM_PORTS  the flit fired by input i is a tail (or single-flit) flit
- i_credit_avail  in  NUM_PORTS  downstream of output o has at least one free buffer
- o_grant  out  NUM_PORTS  input i may fire this cycle
- o_xbar_sel  out  NUM_PORTS*PW  input index routed to output o, slice [o*PW +: PW]
- o_out_active  out  NUM_PORTS  output o is locked to an owner
- o_wd_timeout  out  NUM_PORTS  one-cycle pulse: output o force-released (watchdog build only; tied 0 otherwise)

## Operation
- Per output o, a 2-state FSM: IDLE, LOCKED; registers owner[o] (PW bits) and rr_ptr[o] (PW bits).
- Per input i, derived in_locked[i] = some output is LOCKED with owner == i.
- Eligible request for output o: i_req_valid[i] && i_req_port[i] == o && !in_locked[i]. Requests with i_req_port >= NUM_PORTS are ignored.
- IDLE: if any eligible request, choose the first eligible input searching rr_ptr[o], rr_ptr[o]+1, ... modulo NUM_PORTS. Next state is LOCKED, with owner set to the winner. If there is no eligible request, stay IDLE.
- LOCKED: when i_flit_fire[owner] && i_flit_tail[owner] && o_grant[owner], go to IDLE and set rr_ptr[o] = (owner+1) mod NUM_PORTS. Otherwise hold.
- Outputs arbitrate independently. Two IDLE outputs may grant different inputs on the same edge. An input requests only one output, so it cannot win two.
- o_grant[i] = in_locked[i] && i_credit_avail[o] for the output o that i owns. This is combinational from the lock registers and the credit input.
- i_flit_fire without o_grant is a protocol violation. It does not affect lock state.
- o_xbar_sel[o] = owner[o] while LOCKED, and 0 while IDLE. o_out_active[o] = (state == LOCKED).
- A single-flit packet (head with tail set) locks the output, then releases it on its one fire.

## Timing
- Reset values: all FSMs IDLE, owner = 0, rr_ptr = 0, o_grant = 0, o_xbar_sel = 0, o_out_active = 0, o_wd_timeout = 0.
- Grant latency is 1 cycle. A request sampled at edge N gives o_out_active = 1 after edge N. o_grant follows in the same cycle when credit is available.
- Release: a tail fire in cycle M drops o_out_active and o_grant after edge M+1. A waiting competitor is locked after edge M+2. This gives exactly one idle cycle per output between packets.
- If credit drops while LOCKED, o_grant falls combinationally in the same cycle. The lock is held.
- Reset asserted mid-packet clears all locks immediately. Upstream must drop its partial packet.

## Configuration
- SW_ALLOC_WATCHDOG_EN defined:
  - Per-output counter of $clog2(WD_CYCLES+1) bits. It clears on any owner fire and on entry to LOCKED, and increments each LOCKED cycle without a fire.
  - When the counter reaches WD_CYCLES, the output goes IDLE on the next edge, rr_ptr advances past the owner, and o_wd_timeout[o] pulses for 1 cycle.
- Not defined: no counters, o_wd_timeout is tied 0, and a lock persists until the tail flit.

## Test plan
- Single request: input 1 requests output 3 with credit. The lock, o_grant[1] = 1 and o_xbar_sel[3] = 1 appear 1 cycle later. Fire 3 flits with the tail on the third. o_out_active[3] = 0 the next cycle.
- Contention and round-robin: inputs 0, 2 and 4 all request output 1 continuously, each sending 2-flit packets. Grant order is 0, 2, 4, 0, with one idle cycle between packets.
- Parallel outputs: input 0 requests output 2 while input 3 requests output 4 in the same cycle. Both are locked on the same edge, and o_xbar_sel[2] = 0, o_xbar_sel[4] = 3.
- Credit stall: while output 2 is locked to input 0, drop i_credit_avail[2] for 4 cycles. o_grant[0] = 0 during those cycles, the lock is held, and the grant resumes when credit returns.
- Invalid and illegal inputs:
  - i_req_port = 7 never locks anything.
  - i_flit_fire with the tail set but no grant leaves the lock unchanged.
  - Reset during a packet makes all outputs 0 asynchronously.
- Watchdog (macro defined, WD_CYCLES = 8): lock output 0, then send no fires. o_wd_timeout[0] pulses after 8 idle locked cycles and output 0 returns to IDLE.
